// File: rtl/echo_pkg.sv
// Shared definitions for the echo/feedback mixer.
// Defines the default sample, gain and clip-counter widths, the sample
// clamp limits, and the sample/gain typedefs used by the mixer and its bench.
// Optional feature macro consumed by echo_mix: ECHO_MIX_ROUND_EN.
package echo_pkg;

    localparam int WIDTH  = 12;
    localparam int GAIN_W = 8;
    localparam int CNT_W  = 16;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic [GAIN_W-1:0]       gain_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/echo_mix_sat_add.sv
// sat_add: signed saturating adder.
// Adds two signed WIDTH-bit operands into a WIDTH+1 sum and clamps the result
// back to the signed WIDTH-bit range. clip_o flags that clamping happened.
// Ports:
//   a_i, b_i   in   WIDTH   signed operands
//   sum_o      out  WIDTH   clamped signed sum
//   clip_o     out  1       result was clamped
module sat_add #(
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o,
    output logic                    clip_o
);

    logic signed [WIDTH:0] sum_full;

    assign sum_full = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

    // The WIDTH+1 sum overflowed the WIDTH range exactly when its top two bits differ.
    assign clip_o = sum_full[WIDTH] ^ sum_full[WIDTH-1];

    always_comb begin
        sum_o = sum_full[WIDTH-1:0];
        if (clip_o) begin
            sum_o = sum_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/echo_mix.sv
// echo_mix: echo/feedback mixer downstream of the audio delay line.
// Mixes the dry synth sample with the scaled delayed (wet) sample to form the
// audio output, and a separately scaled copy to feed back into the delay line.
// fb_valid is also the delay line's per-sample advance strobe.
// 3-stage pipeline, one sample per cycle, valid 3 cycles after dry_valid.
// Optional feature: define ECHO_MIX_ROUND_EN to round the gain products half up
// instead of flooring them (same latency either way).
// Ports:
//   clk         in   1        system clock
//   reset       in   1        synchronous active-high reset
//   dry_valid   in   1        dry_in/wet_in valid strobe
//   dry_in      in   WIDTH    dry sample, signed
//   wet_in      in   WIDTH    delayed sample, signed
//   mix_gain    in   GAIN_W   wet gain into out (Q0.GAIN_W)
//   fb_gain     in   GAIN_W   wet gain into fb_out (Q0.GAIN_W)
//   out         out  WIDTH    mixed sample, signed
//   out_valid   out  1        out valid strobe
//   fb_out      out  WIDTH    feedback sample, signed
//   fb_valid    out  1        fb_out valid strobe / delay-line advance
//   clip_count  out  CNT_W    saturating count of clipped samples
module echo_mix
    import echo_pkg::*;
#(
    parameter int WIDTH  = echo_pkg::WIDTH,
    parameter int GAIN_W = echo_pkg::GAIN_W,
    parameter int CNT_W  = echo_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dry_valid,
    input  logic signed [WIDTH-1:0] dry_in,
    input  logic signed [WIDTH-1:0] wet_in,
    input  logic [GAIN_W-1:0]       mix_gain,
    input  logic [GAIN_W-1:0]       fb_gain,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] fb_out,
    output logic                    fb_valid,
    output logic [CNT_W-1:0]        clip_count
);

    localparam int PW = WIDTH + GAIN_W + 1;

`ifdef ECHO_MIX_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (GAIN_W - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    // Stage 1: sample and gains captured together.
    logic                    v1_q;
    logic signed [WIDTH-1:0] dry1_q;
    logic signed [WIDTH-1:0] wet1_q;
    logic [GAIN_W-1:0]       mg1_q;
    logic [GAIN_W-1:0]       fg1_q;

    // Stage 2: dry plus scaled wet terms.
    logic                    v2_q;
    logic signed [WIDTH-1:0] dry2_q;
    logic signed [WIDTH-1:0] pm2_q;
    logic signed [WIDTH-1:0] pf2_q;

    // Stage 3: outputs.
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_q;
    logic signed [WIDTH-1:0] fb_q;
    logic [CNT_W-1:0]        clip_q;

    logic signed [PW-1:0]    pm_full;
    logic signed [PW-1:0]    pf_full;
    logic signed [WIDTH-1:0] pm_d;
    logic signed [WIDTH-1:0] pf_d;
    logic signed [WIDTH-1:0] out_d;
    logic signed [WIDTH-1:0] fb_d;
    logic                    out_clip;
    logic                    fb_clip;
    logic                    unused_bits;

    // Gains are unsigned, so zero-extend before the signed multiply.
    assign pm_full = wet1_q * $signed({1'b0, mg1_q}) + RND;
    assign pf_full = wet1_q * $signed({1'b0, fg1_q}) + RND;

    // Taking bits [GAIN_W +: WIDTH] is an arithmetic shift right by GAIN_W.
    // Since gain < 1 the scaled value always fits in WIDTH bits.
    assign pm_d = pm_full[GAIN_W +: WIDTH];
    assign pf_d = pf_full[GAIN_W +: WIDTH];

    assign unused_bits = ^{pm_full[GAIN_W-1:0], pm_full[PW-1],
                           pf_full[GAIN_W-1:0], pf_full[PW-1]};

    sat_add #(.WIDTH(WIDTH)) u_sat_out (
        .a_i    (dry2_q),
        .b_i    (pm2_q),
        .sum_o  (out_d),
        .clip_o (out_clip)
    );

    sat_add #(.WIDTH(WIDTH)) u_sat_fb (
        .a_i    (dry2_q),
        .b_i    (pf2_q),
        .sum_o  (fb_d),
        .clip_o (fb_clip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q        <= 1'b0;
            dry1_q      <= '0;
            wet1_q      <= '0;
            mg1_q       <= '0;
            fg1_q       <= '0;
            v2_q        <= 1'b0;
            dry2_q      <= '0;
            pm2_q       <= '0;
            pf2_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            fb_q        <= '0;
            clip_q      <= '0;
        end else begin
            v1_q <= dry_valid;
            if (dry_valid) begin
                dry1_q <= dry_in;
                wet1_q <= wet_in;
                mg1_q  <= mix_gain;
                fg1_q  <= fb_gain;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                dry2_q <= dry1_q;
                pm2_q  <= pm_d;
                pf2_q  <= pf_d;
            end

            out_valid_q <= v2_q;
            if (v2_q) begin
                out_q <= out_d;
                fb_q  <= fb_d;
                if ((out_clip || fb_clip) && (clip_q != {CNT_W{1'b1}})) begin
                    clip_q <= clip_q + 1'b1;
                end
            end
        end
    end

    assign out        = out_q;
    assign fb_out     = fb_q;
    assign out_valid  = out_valid_q;
    assign fb_valid   = out_valid_q;
    assign clip_count = clip_q;

endmodule

// File: tb/tb_echo_mix.sv
module tb_echo_mix;
    import echo_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    dry_valid;
    sample_t dry_in;
    sample_t wet_in;
    gain_t   mix_gain;
    gain_t   fb_gain;

    sample_t     out, fb_out, s_out, s_fb_out;
    logic        out_valid, fb_valid, s_out_valid, s_fb_valid;
    logic [15:0] clip_count;
    logic [2:0]  s_clip_count;

    always #5 clk = ~clk;

    echo_mix dut (
        .clk        (clk),
        .reset      (reset),
        .dry_valid  (dry_valid),
        .dry_in     (dry_in),
        .wet_in     (wet_in),
        .mix_gain   (mix_gain),
        .fb_gain    (fb_gain),
        .out        (out),
        .out_valid  (out_valid),
        .fb_out     (fb_out),
        .fb_valid   (fb_valid),
        .clip_count (clip_count)
    );

    // Narrow clip counter instance so counter saturation is reachable quickly.
    echo_mix #(.CNT_W(3)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .dry_valid  (dry_valid),
        .dry_in     (dry_in),
        .wet_in     (wet_in),
        .mix_gain   (mix_gain),
        .fb_gain    (fb_gain),
        .out        (s_out),
        .out_valid  (s_out_valid),
        .fb_out     (s_fb_out),
        .fb_valid   (s_fb_valid),
        .clip_count (s_clip_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each strobe yields an expected result due a fixed
    // number of checking points later.
    typedef struct {
        int due;
        int o;
        int f;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    bit   pend_rst = 1'b1;
    bit   e_valid  = 1'b0;
    int   e_out    = 0;
    int   e_fb     = 0;
    int   e_clip   = 0;
    int   e_sclip  = 0;

    function automatic int scale(input int w, input int g);
        int n, qv;
        n = w * g;
`ifdef ECHO_MIX_ROUND_EN
        n = n + 128;
`endif
        qv = n / 256;
        if (n < 0 && (n % 256) != 0) qv = qv - 1;
        return qv;
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic step(input bit r, input bit dv, input int d, input int w,
                        input int mg, input int fg);
        exp_t e;
        @(negedge clk);
        if (pend_rst) begin
            e_valid = 1'b0; e_out = 0; e_fb = 0; e_clip = 0; e_sclip = 0;
            pend_rst = 1'b0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            e_valid = 1'b1;
            e_out = e.o;
            e_fb  = e.f;
            if (e.clip) begin
                if (e_clip < 65535) e_clip++;
                if (e_sclip < 7)    e_sclip++;
            end
        end else begin
            e_valid = 1'b0;
        end

        chk("out_valid",    int'(out_valid),    int'(e_valid));
        chk("fb_valid",     int'(fb_valid),     int'(e_valid));
        chk("out",          int'(out),          e_out);
        chk("fb_out",       int'(fb_out),       e_fb);
        chk("clip_count",   int'(clip_count),   e_clip);
        chk("s_clip_count", int'(s_clip_count), e_sclip);

        reset     = r;
        dry_valid = dv;
        dry_in    = d[11:0];
        wet_in    = w[11:0];
        mix_gain  = mg[7:0];
        fb_gain   = fg[7:0];

        if (r) begin
            q.delete();
            pend_rst = 1'b1;
        end else if (dv) begin
            int so, sf;
            so = d + scale(w, mg);
            sf = d + scale(w, fg);
            e.due  = cyc + 3;
            e.o    = clamp(so);
            e.f    = clamp(sf);
            e.clip = (clamp(so) != so) || (clamp(sf) != sf);
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; dry_valid = 1'b1; dry_in = 12'sd500; wet_in = '0;
        mix_gain = '0; fb_gain = '0;

        // Reset with strobes asserted: nothing may come out.
        step(1'b1, 1'b1, 500, 0, 0, 0);
        step(1'b1, 1'b1, 500, 0, 0, 0);
        idle(4);
        chk("t1_out_valid", int'(out_valid), 0);

        // Basic mix.
        step(1'b0, 1'b1, 100, 200, 128, 64);
        idle(3);
        chk("t2_out", int'(out), 200);
        chk("t2_fb",  int'(fb_out), 150);
        idle(1);

        // Positive and negative clipping.
        step(1'b0, 1'b1, 2000, 2000, 255, 255);
        idle(3);
        chk("t3_out_hi", int'(out), 2047);
        chk("t3_cnt1",   int'(clip_count), 1);
        step(1'b0, 1'b1, -2048, -2048, 255, 255);
        idle(3);
        chk("t3_out_lo", int'(out), -2048);
        chk("t3_cnt2",   int'(clip_count), 2);

        // Negative product rounding.
        step(1'b0, 1'b1, 0, -3, 128, 0);
        idle(3);
`ifdef ECHO_MIX_ROUND_EN
        chk("t4_round", int'(out), -1);
`else
        chk("t4_floor", int'(out), -2);
`endif

        // Back-to-back strobes with a gain change mid-stream.
        step(1'b0, 1'b1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 2, 0, 0, 0);
        step(1'b0, 1'b1, 3, 256 - 4096 + 4096, 255, 0);
        step(1'b0, 1'b1, 4, 256, 255, 0);
        idle(3);
        chk("t5_last", int'(out), 259);
        idle(1);

        // Reset right after a strobe drops the sample.
        step(1'b0, 1'b1, 10, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        idle(5);
        chk("t6_cnt_rst", int'(clip_count), 0);

        // Clip counter saturation on the narrow instance.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2047, 2047, 255, 0);
        idle(3);
        chk("t6_cnt10",  int'(clip_count), 10);
        chk("t6_satcnt", int'(s_clip_count), 7);

        // Randomized traffic, including extremes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int d, w, mg, fg;
            d  = int'($urandom_range(0, 4095)) - 2048;
            w  = int'($urandom_range(0, 4095)) - 2048;
            mg = int'($urandom_range(0, 255));
            fg = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) mg = 255;
            if ($urandom_range(0, 7) == 0) fg = 0;
            if ($urandom_range(0, 15) == 0) d = ($urandom_range(0, 1) != 0) ? 2047 : -2048;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, d, w, mg, fg);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
